// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared encodings for the ALU control / condition slice
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_EOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_LSL = 3'b110;
    localparam logic [2:0] ALU_LSR = 3'b111;

    typedef enum logic [1:0] {
        OP_DP  = 2'b00,
        OP_MEM = 2'b01,
        OP_BR  = 2'b10,
        OP_RSV = 2'b11
    } op_class_e;

    localparam logic [3:0] CMD_AND   = 4'b0000;
    localparam logic [3:0] CMD_EOR   = 4'b0001;
    localparam logic [3:0] CMD_SUB   = 4'b0010;
    localparam logic [3:0] CMD_ADD   = 4'b0100;
    localparam logic [3:0] CMD_CMP   = 4'b1010;
    localparam logic [3:0] CMD_SLT   = 4'b1011;
    localparam logic [3:0] CMD_ORR   = 4'b1100;
    localparam logic [3:0] CMD_SHIFT = 4'b1101;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    typedef enum logic [1:0] {
        FW_NONE = 2'b00,
        FW_NZ   = 2'b01,
        FW_NZCV = 2'b10
    } flag_wr_e;

    typedef struct packed {
        logic [2:0] alu_control;
        logic       reg_write;
        logic       mem_write;
        logic       pc_src;
        logic       illegal;
        flag_wr_e   flag_wr;
    } decode_t;

    // Bit mask over {N,Z,C,V} selecting which fields a flag write replaces.
    function automatic logic [3:0] flag_mask(input flag_wr_e fw);
        case (fw)
            FW_NZ:   flag_mask = 4'b1100;
            FW_NZCV: flag_mask = 4'b1111;
            default: flag_mask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/cond_unit.sv
// rtl/cond_unit.sv - condition-code evaluation and the {N,Z,C,V} flag register
module cond_unit
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  flag_wr_e   flag_wr,
    input  logic       wr_en,
    input  logic [3:0] alu_flags,
    output logic [3:0] flags,
    output logic       cond_ex
);

    logic [3:0] flags_q;
    logic       n, z, c, v;
    logic [3:0] mask;

    assign {n, z, c, v} = flags_q;
    assign flags        = flags_q;
    assign mask         = flag_mask(flag_wr);

    // Always evaluated on the registered flags, so a flag-setting
    // instruction sees the state left by its predecessor.
    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = ~z & (n == v);
            COND_LE: cond_ex = z | (n != v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= 4'b0000;
        end else if (wr_en && cond_ex) begin
            flags_q <= (flags_q & ~mask) | (alu_flags & mask);
        end
    end

endmodule

// File: rtl/alu_ctrl_cond.sv
// rtl/alu_ctrl_cond.sv - instruction decode to ALU control with conditional writes; ALU_CTRL_SHIFT_EN enables EOR/LSL/LSR
module alu_ctrl_cond
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic [1:0] sh,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    output logic [2:0] alu_control,
    output logic       reg_write,
    output logic       mem_write,
    output logic       pc_src,
    output logic [3:0] flags,
    output logic       illegal
);

    logic [3:0] cmd;
    logic       s_bit;
    decode_t    dec;
    logic       cond_ex;
    logic       gate;

    assign cmd   = funct[4:1];
    assign s_bit = funct[0];

`ifdef ALU_CTRL_SHIFT_EN
    logic unused_bits;
    assign unused_bits = funct[5];
`else
    logic unused_bits;
    assign unused_bits = ^{funct[5], sh};
`endif

    always_comb begin
        dec = '0;
        case (op)
            OP_DP: begin
                dec.reg_write = 1'b1;
                case (cmd)
                    CMD_ADD: begin
                        dec.alu_control = ALU_ADD;
                        if (s_bit) dec.flag_wr = FW_NZCV;
                    end
                    CMD_SUB: begin
                        dec.alu_control = ALU_SUB;
                        if (s_bit) dec.flag_wr = FW_NZCV;
                    end
                    CMD_SLT: begin
                        dec.alu_control = ALU_SLT;
                        if (s_bit) dec.flag_wr = FW_NZCV;
                    end
                    CMD_AND: begin
                        dec.alu_control = ALU_AND;
                        if (s_bit) dec.flag_wr = FW_NZ;
                    end
                    CMD_ORR: begin
                        dec.alu_control = ALU_ORR;
                        if (s_bit) dec.flag_wr = FW_NZ;
                    end
                    // Compare: subtract for flags only, result discarded.
                    CMD_CMP: begin
                        dec.alu_control = ALU_SUB;
                        dec.reg_write   = 1'b0;
                        dec.flag_wr     = FW_NZCV;
                    end
`ifdef ALU_CTRL_SHIFT_EN
                    CMD_EOR: begin
                        dec.alu_control = ALU_EOR;
                        if (s_bit) dec.flag_wr = FW_NZ;
                    end
                    CMD_SHIFT: begin
                        if (s_bit) dec.flag_wr = FW_NZ;
                        case (sh)
                            SH_LSL:  dec.alu_control = ALU_LSL;
                            SH_LSR:  dec.alu_control = ALU_LSR;
                            default: dec.illegal     = 1'b1;
                        endcase
                    end
`endif
                    default: dec.illegal = 1'b1;
                endcase
            end
            OP_MEM: begin
                dec.alu_control = funct[3] ? ALU_ADD : ALU_SUB;
                dec.reg_write   = funct[0];
                dec.mem_write   = ~funct[0];
            end
            OP_BR: begin
                dec.alu_control = ALU_ADD;
                dec.pc_src      = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
        // An undecodable instruction must have no side effects at all.
        if (dec.illegal) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
    end

    cond_unit u_cond_unit (
        .clk       (clk),
        .reset     (reset),
        .cond      (cond),
        .flag_wr   (dec.flag_wr),
        .wr_en     (en & ~dec.illegal),
        .alu_flags (alu_flags),
        .flags     (flags),
        .cond_ex   (cond_ex)
    );

    assign gate        = en & cond_ex & ~reset;
    assign alu_control = dec.alu_control;
    assign illegal     = dec.illegal;
    assign reg_write   = dec.reg_write & gate;
    assign mem_write   = dec.mem_write & gate;
    assign pc_src      = dec.pc_src & gate;

endmodule

// File: tb/tb_alu_ctrl_cond.sv
// tb/tb_alu_ctrl_cond.sv - randomized self-checking bench for alu_ctrl_cond
module tb_alu_ctrl_cond;

    logic       clk = 1'b0;
    logic       reset, en;
    logic [1:0] op, sh;
    logic [5:0] funct;
    logic [3:0] cond, alu_flags;
    logic [2:0] alu_control;
    logic       reg_write, mem_write, pc_src, illegal;
    logic [3:0] flags;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [3:0] m_flags  = 4'b0000;

    typedef struct {
        bit       ok;
        bit [2:0] ctl;
        bit       rw;
        int       fw;   // 0 none, 1 NZ when S, 2 NZCV when S, 3 NZCV always
    } dp_row_t;
    dp_row_t dp_tab[16];

    always #5 clk = ~clk;

    alu_ctrl_cond dut (
        .clk(clk), .reset(reset), .en(en), .op(op), .funct(funct), .sh(sh),
        .cond(cond), .alu_flags(alu_flags), .alu_control(alu_control),
        .reg_write(reg_write), .mem_write(mem_write), .pc_src(pc_src),
        .flags(flags), .illegal(illegal)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Condition = base test selected by cond[3:1], inverted by cond[0].
    function automatic bit cond_pass(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cf, v, base;
        {n, z, cf, v} = f;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf & ~z;
            3'd5: base = (n == v);
            3'd6: base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        return base ^ c[0];
    endfunction

    task automatic model(input logic [1:0] o, input logic [5:0] f, input logic [1:0] s,
                         output bit [2:0] ctl, output bit rw, output bit mw,
                         output bit pc, output bit ill, output bit [3:0] mask);
        int fw;
        dp_row_t row;
        ctl = 0; rw = 0; mw = 0; pc = 0; ill = 0; mask = 0; fw = 0;
        if (o == 2'd0) begin
            row = dp_tab[f[4:1]];
            if (f[4:1] == 4'd13) begin
`ifdef ALU_CTRL_SHIFT_EN
                row = '{ok: (s[1] == 1'b0), ctl: 3'd6 + 3'(s[0]), rw: 1'b1, fw: 1};
`else
                row = '{ok: 1'b0, ctl: 3'd0, rw: 1'b0, fw: 0};
`endif
            end
            if (row.ok) begin
                ctl = row.ctl; rw = row.rw; fw = row.fw;
            end else ill = 1;
        end else if (o == 2'd1) begin
            ctl = f[3] ? 3'd0 : 3'd1;
            rw = f[0]; mw = !f[0];
        end else if (o == 2'd2) begin
            pc = 1;
        end else ill = 1;
        if (fw == 3 || (fw == 2 && f[0])) mask = 4'hF;
        else if (fw == 1 && f[0]) mask = 4'hC;
    endtask

    task automatic step(input logic r, input logic e, input logic [1:0] o, input logic [5:0] f,
                        input logic [1:0] s, input logic [3:0] c, input logic [3:0] af);
        bit [2:0] ctl;
        bit rw, mw, pc, ill, pass;
        bit [3:0] mask;
        logic [3:0] nf;
        @(negedge clk);
        reset = r; en = e; op = o; funct = f; sh = s; cond = c; alu_flags = af;
        #1;
        model(o, f, s, ctl, rw, mw, pc, ill, mask);
        pass = cond_pass(c, m_flags) && e && !r;
        check("alu_control", alu_control, ctl);
        check("illegal", illegal, ill);
        check("reg_write", reg_write, rw & pass);
        check("mem_write", mem_write, mw & pass);
        check("pc_src", pc_src, pc & pass);
        if (r) nf = 4'b0000;
        else if (pass && !ill) nf = (m_flags & ~mask) | (af & mask);
        else nf = m_flags;
        @(posedge clk);
        #1;
        m_flags = nf;
        check("flags", flags, m_flags);
    endtask

    localparam logic [5:0] F_ADD  = {1'b0, 4'b0100, 1'b0};
    localparam logic [5:0] F_ADDS = {1'b0, 4'b0100, 1'b1};
    localparam logic [5:0] F_CMP  = {1'b0, 4'b1010, 1'b0};
    localparam logic [5:0] F_ORRS = {1'b0, 4'b1100, 1'b1};

    initial begin
        int legal_cmds[8];
        logic [3:0] cmd;
        legal_cmds = '{4, 2, 0, 12, 10, 11, 1, 13};
        foreach (dp_tab[i]) dp_tab[i] = '{ok: 1'b0, ctl: 3'd0, rw: 1'b0, fw: 0};
        dp_tab[4]  = '{ok: 1'b1, ctl: 3'd0, rw: 1'b1, fw: 2};
        dp_tab[2]  = '{ok: 1'b1, ctl: 3'd1, rw: 1'b1, fw: 2};
        dp_tab[0]  = '{ok: 1'b1, ctl: 3'd2, rw: 1'b1, fw: 1};
        dp_tab[12] = '{ok: 1'b1, ctl: 3'd3, rw: 1'b1, fw: 1};
        dp_tab[10] = '{ok: 1'b1, ctl: 3'd1, rw: 1'b0, fw: 3};
        dp_tab[11] = '{ok: 1'b1, ctl: 3'd5, rw: 1'b1, fw: 2};
`ifdef ALU_CTRL_SHIFT_EN
        dp_tab[1]  = '{ok: 1'b1, ctl: 3'd4, rw: 1'b1, fw: 1};
`endif
        reset = 1; en = 0; op = 0; funct = 0; sh = 0; cond = 0; alu_flags = 0;

        step(1, 1, 2'b00, F_ADD, 2'b00, 4'b0000, 4'b1111);
        step(0, 1, 2'b00, F_ADD, 2'b00, 4'b0000, 4'b0110);
        check("r030_rw", reg_write, 1'b0);
        check("r030_flags", flags, 4'b0000);

        step(0, 1, 2'b00, F_CMP, 2'b00, 4'b1110, 4'b0100);
        check("r031_cmp_flags", flags, 4'b0100);
        step(0, 1, 2'b00, F_ADD, 2'b00, 4'b0000, 4'b0000);
        check("r031_eq_rw", reg_write, 1'b1);

        step(1, 1, 2'b00, F_ADD, 2'b00, 4'b1110, 4'b0000);
        step(0, 1, 2'b00, F_ORRS, 2'b00, 4'b1110, 4'b1011);
        check("r032_orr_flags", flags, 4'b1000);

        step(0, 1, 2'b00, F_CMP, 2'b00, 4'b1110, 4'b0100);
        step(0, 1, 2'b00, F_ADDS, 2'b00, 4'b0001, 4'b1011);
        check("r033_ne_rw", reg_write, 1'b0);
        check("r033_ne_flags", flags, 4'b0100);
        step(0, 0, 2'b00, F_ADDS, 2'b00, 4'b1110, 4'b1011);
        check("r033_en0_rw", reg_write, 1'b0);
        check("r033_en0_flags", flags, 4'b0100);
        step(0, 0, 2'b10, 6'd0, 2'b00, 4'b1110, 4'b0000);
        check("r033_en0_pc", pc_src, 1'b0);

        step(0, 1, 2'b11, F_ADD, 2'b00, 4'b1110, 4'b0000);
        check("r034_op11_ill", illegal, 1'b1);
        step(0, 1, 2'b00, {1'b0, 4'b0110, 1'b1}, 2'b00, 4'b1110, 4'b1111);
        check("r034_cmd6_ill", illegal, 1'b1);
        check("r034_cmd6_rw", reg_write, 1'b0);
        step(0, 1, 2'b00, {1'b0, 4'b0001, 1'b0}, 2'b00, 4'b1110, 4'b0000);
`ifdef ALU_CTRL_SHIFT_EN
        check("r034_eor_ctl", alu_control, 3'b100);
`else
        check("r034_eor_ill", illegal, 1'b1);
`endif
        step(0, 1, 2'b00, {1'b0, 4'b1101, 1'b0}, 2'b10, 4'b1110, 4'b0000);
        check("sh1_ill", illegal, 1'b1);

        step(0, 1, 2'b00, F_CMP, 2'b00, 4'b1110, 4'b1010);
        step(1, 1, 2'b00, F_CMP, 2'b00, 4'b1110, 4'b1111);
        check("r035_reset_flags", flags, 4'b0000);

        for (int i = 0; i < 600; i++) begin
            logic [1:0] o;
            o   = ($urandom_range(0, 9) < 6) ? 2'b00 : 2'($urandom_range(0, 3));
            cmd = ($urandom_range(0, 9) < 8) ? 4'(legal_cmds[$urandom_range(0, 7)])
                                             : 4'($urandom_range(0, 15));
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) != 0), o,
                 {1'($urandom_range(0, 1)), cmd, 1'($urandom_range(0, 1))},
                 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_cond.md
ALU_CTRL_COND -- requirements
Module: alu_ctrl_cond

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have: en  in  1  instruction valid this cycle; low = bubble.
REQ-004 SHALL have: op  in  2  instruction class (00 data-proc, 01 memory, 10 branch, 11 reserved).
REQ-005 SHALL have: funct  in  6  [4:1] cmd, [0] S/L bit, [3] U bit for memory.
REQ-006 SHALL have: sh  in  2  shift type for cmd 1101 (00 LSL, 01 LSR).
REQ-007 SHALL have: cond  in  4  condition code.
REQ-008 SHALL have: alu_flags  in  4  {N,Z,C,V} from the ALU for the current instruction.
REQ-009 SHALL have: alu_control  out  3  ALU operation select.
REQ-010 SHALL have: reg_write, mem_write, pc_src  out  1 each  condition-gated writes.
REQ-011 SHALL have: flags  out  4  registered {N,Z,C,V}; illegal  out  1  undecodable instruction.

Function
REQ-012 Decode SHALL be combinational, same cycle as inputs; only the flag register is sequential.
REQ-013 op=00 cmd map SHALL be: 0100 ADD->000, 0010 SUB->001, 0000 AND->010, 1100 ORR->011, 1010 CMP->001, 1011 SLT->101, 0001 EOR->100, 1101 sh=00 LSL->110, sh=01 LSR->111.
REQ-014 op=00 SHALL assert reg_write for all listed cmds except CMP.
REQ-015 op=01 SHALL drive alu_control 000 if funct[3]=1 else 001; funct[0]=1 load (reg_write), 0 store (mem_write).
REQ-016 op=10 SHALL drive alu_control 000 and pc_src; no reg/mem write.
REQ-017 op=11, unlisted cmd, or cmd 1101 with sh[1]=1 SHALL assert illegal, alu_control 000, all writes 0, no flag update.
REQ-018 Flag write: ADD/SUB/SLT with S=1 write NZCV; AND/ORR/EOR/LSL/LSR with S=1 write NZ only; CMP always writes NZCV; op 01/10 never write.
REQ-019 cond_ex SHALL use registered flags: EQ Z, NE ~Z, CS C, CC ~C, MI N, PL ~N, VS V, VC ~V, HI C&~Z, LS ~C|Z, GE N==V, LT N!=V, GT ~Z&(N==V), LE Z|(N!=V), AL 1, 1111 0.
REQ-020 reg_write, mem_write, pc_src SHALL be decoded value AND cond_ex AND en.
REQ-021 Flags SHALL update on clk edge only when en & cond_ex & ~illegal & flag-write; selected fields from alu_flags, others held.
REQ-022 Instruction that writes flags SHALL evaluate cond on old flags; new flags visible to the next instruction (1-cycle latency, no bypass).
REQ-023 en=0 SHALL force all write outputs 0 and hold flags; alu_control/illegal still decode.

Reset
REQ-024 reset=1 at clk edge SHALL set flags to 0000, overriding any same-cycle flag write.
REQ-025 During reset reg_write, mem_write, pc_src SHALL be 0; after reset, EQ fails, NE/AL pass.

Configuration
REQ-026 With ALU_CTRL_SHIFT_EN defined, EOR/LSL/LSR decode per REQ-013.
REQ-027 Without ALU_CTRL_SHIFT_EN, cmds 0001 and 1101 SHALL be illegal per REQ-017; encodings 100/110/111 never emitted.

Structure
REQ-028 Package alu_pkg SHALL hold ALU control encodings (000-111), op class enum, cmd constants, cond code enum.
REQ-029 Condition evaluation plus flag register SHALL be sub-module cond_unit; decode stays in alu_ctrl_cond.

Verification
REQ-030 Reset, then cond=0000 ADD op=00 cmd=0100 S=0 en=1 -> alu_control 000, reg_write 0, flags 0000.
REQ-031 CMP (cmd 1010) alu_flags=0100, cond=1110 -> reg_write 0, flags 0100 next cycle; next cond=0000 ADD -> reg_write 1.
REQ-032 ORR S=1 alu_flags=1011 with flags=0000 -> flags 1000 next cycle (C,V held 0).
REQ-033 ADD S=1 cond=0001 while flags Z=1 -> reg_write 0, flags unchanged; same with en=0 -> all writes 0.
REQ-034 op=11 and cmd 0110 -> illegal 1, writes 0; cmd 0001 -> alu_control 100 with macro, illegal 1 without.
REQ-035 reset asserted same cycle as CMP with alu_flags=1111 -> flags 0000 after edge.
